// File: rtl/demux_receiver_pkg.sv
// Shared types and sizing for the channel demux receiver: FSM states,
// channel/address/counter widths and the one-hot channel decode.
package demux_receiver_pkg;

    localparam int NUM_CH    = 32;
    localparam int ADDR_W    = 5;
    localparam int CNT_W     = 16;
    localparam int LOW_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        WRLOW = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] ch_decode(input logic [ADDR_W-1:0] idx);
        logic [NUM_CH-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/demux_receiver_if.sv
// Pin-side bus of the demux receiver: host pins in, switch state and status out.
interface demux_receiver_if;
    import demux_receiver_pkg::*;

    logic                cs_n;
    logic                wr_n;
    logic                ena_n;
    logic [ADDR_W-1:0]   set_ch;
    logic [ADDR_W-1:0]   ch_idx;
    logic [NUM_CH-1:0]   ch_onehot;
    logic                ch_valid;
    logic                wr_strobe;
    logic [CNT_W-1:0]    wr_count;
    logic                err_short;

    modport master (
        output cs_n, wr_n, ena_n, set_ch,
        input  ch_idx, ch_onehot, ch_valid, wr_strobe, wr_count, err_short
    );

    modport slave (
        input  cs_n, wr_n, ena_n, set_ch,
        output ch_idx, ch_onehot, ch_valid, wr_strobe, wr_count, err_short
    );

endinterface

// File: rtl/demux_receiver_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin group; the reset value is a
// port so each pin can park at its own inactive level.
module pin_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= rst_val;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/demux_receiver.sv
// Channel-select demux receiver: synchronizes the host pins, validates write
// pulse length and drives a registered one-hot switch state.
module demux_receiver
    import demux_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WR_LOW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    demux_receiver_if.slave  bus
);

    localparam logic [LOW_CNT_W-1:0] MIN_LOW  = LOW_CNT_W'(MIN_WR_LOW);
    localparam logic [1:0]           FLUSH_N  = 2'(SYNC_STAGES);

    logic [1:0]           rst_sync_q;
    logic                 rst_n_int;

    logic                 cs_s;
    logic                 wr_s;
    logic                 ena_s;
    logic [ADDR_W-1:0]    set_s;

    state_t               state_q,  state_nxt;
    logic [LOW_CNT_W-1:0] low_cnt_q, low_cnt_nxt;
    logic [ADDR_W-1:0]    ch_idx_q, ch_idx_nxt;
    logic [NUM_CH-1:0]    onehot_q, onehot_nxt;
    logic                 valid_q,  valid_nxt;
    logic                 strobe_q, strobe_nxt;
    logic [CNT_W-1:0]     count_q,  count_nxt;
    logic                 err_q,    err_nxt;

    logic [1:0]           flush_cnt_q;
    logic                 flushed;
    logic                 block_q;

    // Async assert, clean deassert of the internal reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_int = rst_sync_q[1];

    pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst_n(rst_n_int), .rst_val(1'b1), .d(bus.cs_n), .q(cs_s)
    );

    pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_wr (
        .clk(clk), .rst_n(rst_n_int), .rst_val(1'b1), .d(bus.wr_n), .q(wr_s)
    );

    pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ena (
        .clk(clk), .rst_n(rst_n_int), .rst_val(1'b1), .d(bus.ena_n), .q(ena_s)
    );

    pin_sync #(.WIDTH(ADDR_W), .STAGES(SYNC_STAGES)) u_sync_set (
        .clk(clk), .rst_n(rst_n_int), .rst_val('0), .d(bus.set_ch), .q(set_s)
    );

    // After reset, the synchronizers show parked-high controls until flushed; a
    // write already underway must not be picked up until cs_n is seen truly high.
    assign flushed = (flush_cnt_q == FLUSH_N);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            flush_cnt_q <= 2'd0;
            block_q     <= 1'b1;
        end else begin
            if (!flushed)        flush_cnt_q <= flush_cnt_q + 2'd1;
            if (flushed && cs_s) block_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= IDLE;
            low_cnt_q <= '0;
            ch_idx_q  <= '0;
            onehot_q  <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            low_cnt_q <= low_cnt_nxt;
            ch_idx_q  <= ch_idx_nxt;
            onehot_q  <= onehot_nxt;
            valid_q   <= valid_nxt;
            strobe_q  <= strobe_nxt;
            count_q   <= count_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        low_cnt_nxt = low_cnt_q;
        ch_idx_nxt  = ch_idx_q;
        valid_nxt   = valid_q;
        strobe_nxt  = 1'b0;
        count_nxt   = count_q;
        err_nxt     = err_q;

        case (state_q)
            IDLE: begin
                if (!cs_s && !block_q) state_nxt = SEL;
            end
            SEL: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                end else if (!wr_s) begin
                    state_nxt   = WRLOW;
                    low_cnt_nxt = LOW_CNT_W'(1);
                end
            end
            WRLOW: begin
                // A wr_n rise wins over a simultaneous cs_n rise.
                if (wr_s) begin
                    if (low_cnt_q >= MIN_LOW) begin
                        ch_idx_nxt = set_s;
                        valid_nxt  = 1'b1;
                        strobe_nxt = 1'b1;
                        if (count_q != '1) count_nxt = count_q + CNT_W'(1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = cs_s ? IDLE : SEL;
                end else if (cs_s) begin
                    state_nxt = IDLE;
                end else if (low_cnt_q != '1) begin
                    low_cnt_nxt = low_cnt_q + LOW_CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        onehot_nxt = (!ena_s && valid_nxt) ? ch_decode(ch_idx_nxt) : '0;
    end

    assign bus.ch_idx    = ch_idx_q;
    assign bus.ch_onehot = onehot_q;
    assign bus.ch_valid  = valid_q;
    assign bus.wr_strobe = strobe_q;
    assign bus.wr_count  = count_q;
    assign bus.err_short = err_q;

endmodule

// File: tb/tb_demux_receiver.sv
// Directed bench for demux_receiver: expected channels are queued when a write
// is driven and matched against each wr_strobe pulse.
module tb_demux_receiver;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [4:0] sb[$];
    logic prev_strobe;
    int   lat;

    demux_receiver_if bus();

    demux_receiver #(.SYNC_STAGES(2), .MIN_WR_LOW(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] ch, input int low_cycles, input bit expect_commit);
        bus.set_ch = ch;
        bus.wr_n   = 1'b0;
        tick(low_cycles);
        bus.wr_n   = 1'b1;
        if (expect_commit) sb.push_back(ch);
        tick(6);
    endtask

    // Every strobe must be single-cycle and carry the channel queued for it.
    initial prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                check("strobe_unexpected", 32'(bus.wr_strobe), 32'd0);
            end else begin
                logic [4:0] exp_ch;
                exp_ch = sb.pop_front();
                check("strobe_ch_idx", 32'(bus.ch_idx), 32'(exp_ch));
                check("strobe_width", 32'(prev_strobe), 32'd0);
            end
        end
        prev_strobe = bus.wr_strobe;
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        bus.cs_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.ena_n   = 1'b0;
        bus.set_ch  = 5'd0;
        tick(3);

        check("rst_ch_idx",    32'(bus.ch_idx),    32'd0);
        check("rst_onehot",    bus.ch_onehot,      32'd0);
        check("rst_valid",     32'(bus.ch_valid),  32'd0);
        check("rst_strobe",    32'(bus.wr_strobe), 32'd0);
        check("rst_count",     32'(bus.wr_count),  32'd0);
        check("rst_err",       32'(bus.err_short), 32'd0);

        rst = 1'b1;
        tick(8);

        // Basic write to channel 17 with latency measurement.
        bus.cs_n = 1'b0;
        tick(4);
        bus.set_ch = 5'd17;
        bus.wr_n   = 1'b0;
        tick(4);
        bus.wr_n = 1'b1;
        sb.push_back(5'd17);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.wr_strobe === 1'b1) break;
        end
        check("latency", 32'(lat), 32'd3);
        tick(3);
        check("w17_ch_idx", 32'(bus.ch_idx),   32'd17);
        check("w17_onehot", bus.ch_onehot,     32'h0002_0000);
        check("w17_count",  32'(bus.wr_count), 32'd1);
        check("w17_valid",  32'(bus.ch_valid), 32'd1);
        check("w17_err",    32'(bus.err_short), 32'd0);

        // Short pulse is rejected and flags a sticky error.
        do_write(5'd9, 1, 1'b0);
        check("short_err",    32'(bus.err_short), 32'd1);
        check("short_ch_idx", 32'(bus.ch_idx),    32'd17);
        check("short_count",  32'(bus.wr_count),  32'd1);

        // Output enable gates the one-hot only.
        do_write(5'd3, 3, 1'b1);
        check("w3_ch_idx", 32'(bus.ch_idx), 32'd3);
        check("w3_onehot", bus.ch_onehot,   32'h0000_0008);
        bus.ena_n = 1'b1;
        tick(5);
        check("ena_off_onehot", bus.ch_onehot,   32'd0);
        check("ena_off_ch_idx", 32'(bus.ch_idx), 32'd3);
        bus.ena_n = 1'b0;
        tick(5);
        check("ena_on_onehot", bus.ch_onehot,      32'h0000_0008);
        check("err_sticky",    32'(bus.err_short), 32'd1);

        // cs_n rising mid-write aborts silently.
        bus.set_ch = 5'd12;
        bus.wr_n   = 1'b0;
        tick(3);
        bus.cs_n = 1'b1;
        tick(3);
        bus.wr_n = 1'b1;
        tick(6);
        check("abort_ch_idx", 32'(bus.ch_idx),    32'd3);
        check("abort_count",  32'(bus.wr_count),  32'd2);
        check("abort_err",    32'(bus.err_short), 32'd1);
        bus.cs_n = 1'b0;
        tick(4);
        do_write(5'd31, 3, 1'b1);
        check("w31_onehot", bus.ch_onehot,     32'h8000_0000);
        check("w31_count",  32'(bus.wr_count), 32'd3);

        // Back-to-back writes inside one select period.
        do_write(5'd0, 3, 1'b1);
        do_write(5'd1, 3, 1'b1);
        do_write(5'd2, 3, 1'b1);
        check("b2b_count",  32'(bus.wr_count), 32'd6);
        check("b2b_onehot", bus.ch_onehot,     32'h0000_0004);
        check("b2b_ch_idx", 32'(bus.ch_idx),   32'd2);

        // wr_n and cs_n rising together still commit.
        bus.set_ch = 5'd7;
        bus.wr_n   = 1'b0;
        tick(3);
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        sb.push_back(5'd7);
        tick(6);
        check("simul_ch_idx", 32'(bus.ch_idx),   32'd7);
        check("simul_count",  32'(bus.wr_count), 32'd7);
        check("sb_drained_pre_rst", 32'(sb.size()), 32'd0);

        // Reset in the middle of a write; the in-flight write must be dropped.
        bus.cs_n = 1'b0;
        tick(4);
        bus.set_ch = 5'd20;
        bus.wr_n   = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("midrst_ch_idx", 32'(bus.ch_idx),    32'd0);
        check("midrst_onehot", bus.ch_onehot,      32'd0);
        check("midrst_valid",  32'(bus.ch_valid),  32'd0);
        check("midrst_count",  32'(bus.wr_count),  32'd0);
        check("midrst_err",    32'(bus.err_short), 32'd0);
        rst = 1'b1;
        tick(8);
        bus.wr_n = 1'b1;
        tick(8);
        check("post_rst_ch_idx", 32'(bus.ch_idx),   32'd0);
        check("post_rst_valid",  32'(bus.ch_valid), 32'd0);
        check("post_rst_count",  32'(bus.wr_count), 32'd0);

        bus.cs_n = 1'b1;
        tick(5);
        bus.cs_n = 1'b0;
        tick(4);
        do_write(5'd22, 3, 1'b1);
        check("w22_ch_idx", 32'(bus.ch_idx),   32'd22);
        check("w22_onehot", bus.ch_onehot,     32'h0040_0000);
        check("w22_count",  32'(bus.wr_count), 32'd1);
        check("w22_valid",  32'(bus.ch_valid), 32'd1);
        check("sb_drained", 32'(sb.size()),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_receiver.md
DEMUX_RECEIVER -- requirements
Module: demux_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on every pin input, legal range 2..3.
REQ-002 Parameter MIN_WR_LOW, default 2: minimum synchronized wr_n low time in clk cycles for a write to be accepted, legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cs_n  input  1  chip select pin, active-low, asynchronous to clk.
REQ-006 wr_n  input  1  write strobe pin, active-low; the address is latched on its rising edge.
REQ-007 ena_n  input  1  output enable pin, active-low; when high, all switches are open.
REQ-008 set_ch  input  5  channel address pins.
REQ-009 ch_idx  output  5  last committed channel address.
REQ-010 ch_onehot  output  32  one-hot switch state: bit ch_idx is set when enabled and valid, otherwise all bits are zero.
REQ-011 ch_valid  output  1  high once at least one write has been committed since reset.
REQ-012 wr_strobe  output  1  single-cycle pulse on each committed write.
REQ-013 wr_count  output  16  count of committed writes, saturating.
REQ-014 err_short  output  1  sticky flag set by a rejected short write pulse.

Function
REQ-015 cs_n, wr_n, ena_n and set_ch each pass through a SYNC_STAGES flop chain of equal depth, so address and controls stay cycle-aligned.
REQ-016 The FSM has three states: IDLE, SEL and WRLOW. All conditions below refer to synchronized signals.
- IDLE: cs_n=0 -> SEL.
- SEL: cs_n=1 -> IDLE; wr_n=0 -> WRLOW, and low_cnt is loaded with 1.
- WRLOW: wr_n=0 and cs_n=0 -> stay, low_cnt increments and saturates at 255; wr_n=1 -> commit check, then SEL if cs_n=0, else IDLE; cs_n=1 while wr_n=0 -> IDLE, write aborted, no error.
REQ-017 Commit check: when low_cnt>=MIN_WR_LOW, load ch_idx from synchronized set_ch sampled in the same cycle wr_n is seen high, pulse wr_strobe, set ch_valid, and increment wr_count; otherwise set err_short and change nothing else.
REQ-018 Latency: wr_n rising edge captured by clk edge k gives wr_strobe high for exactly the cycle after edge k+SYNC_STAGES, and ch_idx updated in that same cycle.
REQ-019 ch_onehot is registered and follows ch_idx, ena_n and ch_valid with zero added cycles: it updates in the same cycle as ch_idx.
REQ-020 ena_n=1 forces ch_onehot=0 and does not affect ch_idx or the FSM; writes are accepted while ena_n=1.
REQ-021 Simultaneous wr_n and cs_n rise in the same synchronized cycle: the write commits, subject to the REQ-017 length check, and the next state is IDLE.
REQ-022 wr_count saturates at 16'hFFFF and never wraps.
REQ-023 err_short clears only on reset.
REQ-024 Back-to-back writes within one cs_n low period are each committed independently.

Reset
REQ-025 rst=0 asynchronously forces: all synchronizer flops to inactive (controls 1, set_ch 0), FSM=IDLE, low_cnt=0, ch_idx=0, ch_onehot=0, ch_valid=0, wr_strobe=0, wr_count=0, err_short=0.
REQ-026 Reset asserted mid-write discards the write; after rst is released, a wr_n low period already in progress is not committed until cs_n returns high and the FSM re-enters SEL.
REQ-027 Reset release is synchronized internally by a 2-flop chain, so state leaves reset on a clean clk edge.

Structure
REQ-028 The shared package holds the FSM state enumeration, channel count (32), address width (5) and wr_count width (16).
REQ-029 One sub-module, pin_sync, is instantiated per input signal: a parameterized-width, SYNC_STAGES-deep synchronizer with an asynchronous active-low reset value port.
REQ-030 The FSM, counters and one-hot decode reside in demux_receiver.

Verification
REQ-031 Reset, then cs_n=0, set_ch=5'd17, wr_n low for 4 clk cycles then high, ena_n=0 -> one wr_strobe pulse SYNC_STAGES+1 cycles after the rise, ch_idx=17, ch_onehot=32'h0002_0000, wr_count=1, ch_valid=1.
REQ-032 wr_n low for 1 cycle with MIN_WR_LOW=2 -> no strobe, ch_idx unchanged, err_short=1 until the next reset.
REQ-033 After a committed write to 5'd3, drive ena_n=1 -> ch_onehot=0 and ch_idx=3; drive ena_n=0 again -> ch_onehot=32'h0000_0008.
REQ-034 cs_n rises while wr_n is still low -> no strobe, no error, FSM=IDLE; a following full write to 5'd31 -> ch_onehot=32'h8000_0000.
REQ-035 Three back-to-back writes (0, 1, 2) under one cs_n low period -> three strobes, wr_count=3, final ch_onehot=32'h0000_0004.
REQ-036 Assert rst=0 mid-WRLOW, then release while wr_n is still low -> all outputs at reset values and no commit until a new cs_n cycle.
